mac_psum_accum: RTL and testbench

//   Partial-sum sequencer and accumulator directly downstream of the mac stage.

---
 rtl/mac_psum_accum.sv | 126 ++++++++++++
 tb/tb_mac_psum_accum.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_psum_accum.sv
// Partial-sum sequencer/accumulator behind the mac stage: runs one N-beat job, then hands the
// final sum to writeback over valid/ready. Optional output requantisation via OUT_REQUANT_EN.
module mac_psum_accum #(
   parameter int unsigned BEAT_W = 8,
   parameter int unsigned PSUM_W = 24
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [1:0]        i_mode,
   input  logic [BEAT_W-1:0] i_num_beats,
`ifdef OUT_REQUANT_EN
   input  logic [4:0]        i_shift,
`endif
   input  logic              i_in_valid,
   output logic              o_in_ready,
   output logic [1:0]        o_mode,
   output logic [PSUM_W-1:0] o_psum,
   input  logic [PSUM_W-1:0] i_mac_result,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [PSUM_W-1:0] o_out_data,
   output logic              o_busy,
   output logic              o_err
);

   localparam logic [1:0] ModeInt8 = 2'd0;

   typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

   state_e            state_q;
   logic [PSUM_W-1:0] acc_q;
   logic [BEAT_W-1:0] cnt_q;
   logic [1:0]        mode_q;
   logic              err_q;
   logic              accept_start;

   // A start is only taken from IDLE, or from DONE in the same cycle the result is consumed.
   assign accept_start = i_start &
                         ((state_q == StIdle) | ((state_q == StDone) & i_out_ready));

`ifdef OUT_REQUANT_EN
   logic [4:0]        shift_q;
   logic [PSUM_W-1:0] out_q;

   function automatic logic [PSUM_W-1:0] requant(input logic [PSUM_W-1:0] val,
                                                 input logic [4:0]        sh);
      logic signed [63:0] wide;
      logic signed [63:0] rnd;
      logic        [7:0]  s8;
      wide = {{(64 - PSUM_W){val[PSUM_W-1]}}, val};
      rnd  = wide + ((sh != 5'd0) ? (64'sd1 <<< (sh - 5'd1)) : 64'sd0);
      rnd  = rnd >>> sh;
      if (rnd > 64'sd127) begin
         s8 = 8'h7f;
      end else if (rnd < -64'sd128) begin
         s8 = 8'h80;
      end else begin
         s8 = rnd[7:0];
      end
      return {{(PSUM_W - 8){s8[7]}}, s8};
   endfunction
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         acc_q   <= '0;
         cnt_q   <= '0;
         mode_q  <= ModeInt8;
         err_q   <= 1'b0;
`ifdef OUT_REQUANT_EN
         shift_q <= '0;
         out_q   <= '0;
`endif
      end else begin
         err_q <= i_start & ~accept_start;
         if (accept_start) begin
            mode_q  <= i_mode;
            cnt_q   <= i_num_beats;
            acc_q   <= '0;
            state_q <= (i_num_beats == '0) ? StDone : StAccum;
`ifdef OUT_REQUANT_EN
            shift_q <= i_shift;
            // Rounding term is always below 2^shift, so a zero accumulator requantises to zero.
            out_q   <= '0;
`endif
         end else begin
            unique case (state_q)
               StAccum: begin
                  if (i_in_valid) begin
                     acc_q <= i_mac_result;
                     cnt_q <= cnt_q - BEAT_W'(1);
                     if (cnt_q == BEAT_W'(1)) begin
                        state_q <= StDone;
`ifdef OUT_REQUANT_EN
                        out_q   <= requant(i_mac_result, shift_q);
`endif
                     end
                  end
               end
               StDone: begin
                  if (i_out_ready) begin
                     state_q <= StIdle;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign o_in_ready  = (state_q == StAccum);
   assign o_out_valid = (state_q == StDone);
   assign o_busy      = (state_q != StIdle);
   assign o_err       = err_q;
   assign o_mode      = mode_q;
   assign o_psum      = acc_q;
`ifdef OUT_REQUANT_EN
   assign o_out_data  = out_q;
`else
   assign o_out_data  = acc_q;
`endif

endmodule

// File: tb/tb_mac_psum_accum.sv
// Directed bench for mac_psum_accum: expected final sums queued when a job is driven and
// popped on the output handshake. Covers the OUT_REQUANT_EN build when that macro is defined.
module tb_mac_psum_accum;

   localparam int BW = 8;
   localparam int PW = 24;
   localparam logic [1:0] INT8     = 2'd0;
   localparam logic [1:0] INT4     = 2'd1;
   localparam logic [1:0] INT4_VSQ = 2'd2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [1:0]    mode = INT8;
   logic [BW-1:0] nb = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    o_mode;
   logic [PW-1:0] psum;
   logic [PW-1:0] res = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [PW-1:0] out_data;
   logic          busy;
   logic          err;
`ifdef OUT_REQUANT_EN
   logic [4:0]    shift = '0;
`endif

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;
   logic [PW-1:0] exp_q[$];

   mac_psum_accum #(.BEAT_W(BW), .PSUM_W(PW)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start),
      .i_mode       (mode),
      .i_num_beats  (nb),
`ifdef OUT_REQUANT_EN
      .i_shift      (shift),
`endif
      .i_in_valid   (in_valid),
      .o_in_ready   (in_ready),
      .o_mode       (o_mode),
      .o_psum       (psum),
      .i_mac_result (res),
      .o_out_valid  (out_valid),
      .i_out_ready  (out_ready),
      .o_out_data   (out_data),
      .o_busy       (busy),
      .o_err        (err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [PW-1:0] b(input logic x);
      return {{(PW - 1){1'b0}}, x};
   endfunction

   function automatic logic [PW-1:0] m(input logic [1:0] x);
      return {{(PW - 2){1'b0}}, x};
   endfunction

   task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Check the running sum fed to mac, then present one valid beat.
   task automatic beat(input int r, input int exp_psum, input string tag);
      check(tag, psum, PW'(exp_psum));
      in_valid = 1'b1;
      res      = PW'(r);
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int waited = 0;
      logic [PW-1:0] e;
      while (out_valid !== 1'b1 && waited < 20) begin
         step();
         waited++;
      end
      check({tag, "_valid"}, b(out_valid), b(1'b1));
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check({tag, "_data"}, out_data, e);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_idle"}, b(busy), b(1'b0));
   endtask

   task automatic job1(input string tag);
      start = 1'b1;
      mode  = INT8;
      nb    = BW'(3);
      step();
      start = 1'b0;
      exp_q.push_back(PW'(-5));
      check({tag, "_busy"}, b(busy), b(1'b1));
      check({tag, "_rdy"}, b(in_ready), b(1'b1));
      beat(10, 0, {tag, "_ps0"});
      beat(25, 10, {tag, "_ps1"});
      beat(-5, 25, {tag, "_ps2"});
      check({tag, "_vld_after3"}, b(out_valid), b(1'b1));
      drain(tag);
   endtask

   initial begin
      step();
      step();
      check("rst_rdy", b(in_ready), b(1'b0));
      check("rst_vld", b(out_valid), b(1'b0));
      check("rst_busy", b(busy), b(1'b0));
      check("rst_err", b(err), b(1'b0));
      check("rst_psum", psum, '0);
      check("rst_data", out_data, '0);
      check("rst_mode", m(o_mode), m(INT8));
      rst_n = 1'b1;
      step();

      job1("t1");

      // Beats separated by two idle cycles; sum must hold across the gaps.
      start = 1'b1;
      mode  = INT4;
      nb    = BW'(4);
      step();
      start = 1'b0;
      exp_q.push_back(PW'(4));
      for (int i = 1; i <= 4; i++) begin
         beat(i, i - 1, "t2_ps");
         if (i < 4) begin
            step();
            step();
         end
      end
      check("t2_vld", b(out_valid), b(1'b1));
      check("t2_mode", m(o_mode), m(INT4));
      in_valid = 1'b1;
      res      = PW'(99);
      step();
      in_valid = 1'b0;
      check("t2_rdy_done", b(in_ready), b(1'b0));
      check("t2_no5th", out_data, PW'(4));

      // Hold the result, then consume it together with a new start.
      for (int i = 0; i < 5; i++) begin
         check("t3_hold", out_data, PW'(4));
         check("t3_hold_vld", b(out_valid), b(1'b1));
         step();
      end
      out_ready = 1'b1;
      start     = 1'b1;
      mode      = INT4_VSQ;
      nb        = BW'(2);
      check("t3_data", out_data, exp_q.size() > 0 ? exp_q.pop_front() : 'x);
      step();
      out_ready = 1'b0;
      start     = 1'b0;
      exp_q.push_back(PW'(8));
      check("t3_rdy", b(in_ready), b(1'b1));
      check("t3_vld", b(out_valid), b(1'b0));
      check("t3_mode", m(o_mode), m(INT4_VSQ));
      check("t3_psum", psum, '0);

      // Start during ACCUM is dropped and flagged for exactly one cycle.
      start = 1'b1;
      mode  = INT4;
      nb    = BW'(5);
      step();
      start = 1'b0;
      check("t4_err", b(err), b(1'b1));
      check("t4_mode_kept", m(o_mode), m(INT4_VSQ));
      step();
      check("t4_err_clr", b(err), b(1'b0));
      beat(7, 0, "t4_ps0");
      beat(8, 7, "t4_ps1");
      drain("t4");

      start = 1'b1;
      nb    = '0;
      step();
      start = 1'b0;
      exp_q.push_back('0);
      check("t4_zero_rdy", b(in_ready), b(1'b0));
      check("t4_zero_vld", b(out_valid), b(1'b1));
      drain("t4z");

      // Asynchronous reset in the middle of a job.
      start = 1'b1;
      nb    = BW'(3);
      step();
      start = 1'b0;
      beat(10, 0, "t5_ps0");
      #2 rst_n = 1'b0;
      #1;
      check("t5_rdy", b(in_ready), b(1'b0));
      check("t5_busy", b(busy), b(1'b0));
      check("t5_psum", psum, '0);
      check("t5_vld", b(out_valid), b(1'b0));
      step();
      rst_n = 1'b1;
      step();
      job1("t5j");

`ifdef OUT_REQUANT_EN
      begin
         int acc_v[4] = '{1000, 5000, -3000, -6};
         int sh_v[4]  = '{3, 2, 2, 2};
         int exp_v[4] = '{125, 127, -128, -1};
         for (int i = 0; i < 4; i++) begin
            start = 1'b1;
            nb    = BW'(1);
            shift = 5'(sh_v[i]);
            step();
            start = 1'b0;
            shift = '0;
            exp_q.push_back(PW'(exp_v[i]));
            beat(acc_v[i], 0, "t6_ps");
            drain("t6");
         end
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
